// File: rtl/long_mul_unit.sv
// Multicycle 32x32->64 long multiplier (UMULL/SMULL/UMLAL/SMLAL) that drives the
// register file's dual write port for one cycle when the result is ready.
module long_mul_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_signed,
    input  logic         accumulate,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] acc_lo,
    input  logic [N-1:0] acc_hi,
    input  logic [3:0]   rdlo_addr,
    input  logic [3:0]   rdhi_addr,
    output logic         busy,
    output logic         done,
    output logic         we3,
    output logic         w_64,
    output logic [3:0]   wa3_32,
    output logic [3:0]   wa3_64,
    output logic [N-1:0] wd3_32,
    output logic [N-1:0] wd3_64,
    output logic         flag_n,
    output logic         flag_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [N-1:0]   ONE_N   = 1;
    localparam logic [2*N-1:0] ONE_2N  = 1;
    localparam logic [5:0]     LAST_IT = 6'(N - 1);

    state_t state_reg, state_next;

    logic [2*N-1:0] mcand_reg;
    logic [2*N-1:0] product_reg;
    logic [2*N-1:0] acc_reg;
    logic [N-1:0]   mplier_reg;
    logic [5:0]     cnt_reg;
    logic           neg_reg;
    logic           signed_reg;
    logic           accum_reg;
    logic [3:0]     lo_addr_reg;
    logic [3:0]     hi_addr_reg;

    logic [2*N-1:0] result_reg;
    logic [3:0]     wa_lo_reg;
    logic [3:0]     wa_hi_reg;
    logic           flag_n_reg;
    logic           flag_z_reg;

    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [2*N-1:0] signed_product;
    logic [2*N-1:0] fix_result;

    // Signed mode works on magnitudes; 0x80000000 maps to itself, which is
    // exactly its magnitude when read as unsigned.
    always_comb begin
        a_mag = (is_signed && a[N-1]) ? (~a + ONE_N) : a;
        b_mag = (is_signed && b[N-1]) ? (~b + ONE_N) : b;
    end

    always_comb begin
        signed_product = (signed_reg && neg_reg) ? (~product_reg + ONE_2N) : product_reg;
        fix_result     = accum_reg ? (signed_product + acc_reg) : signed_product;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = MUL;
            MUL:  if (cnt_reg == LAST_IT) state_next = FIX;
            FIX:  state_next = WB;
            WB:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_reg   <= '0;
            product_reg <= '0;
            acc_reg     <= '0;
            mplier_reg  <= '0;
            cnt_reg     <= '0;
            neg_reg     <= 1'b0;
            signed_reg  <= 1'b0;
            accum_reg   <= 1'b0;
            lo_addr_reg <= '0;
            hi_addr_reg <= '0;
            result_reg  <= '0;
            wa_lo_reg   <= '0;
            wa_hi_reg   <= '0;
            flag_n_reg  <= 1'b0;
            flag_z_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg   <= {{N{1'b0}}, a_mag};
                        mplier_reg  <= b_mag;
                        product_reg <= '0;
                        cnt_reg     <= '0;
                        neg_reg     <= a[N-1] ^ b[N-1];
                        signed_reg  <= is_signed;
                        accum_reg   <= accumulate;
                        acc_reg     <= {acc_hi, acc_lo};
                        lo_addr_reg <= rdlo_addr;
                        hi_addr_reg <= rdhi_addr;
                    end
                end
                MUL: begin
                    if (mplier_reg[0]) begin
                        product_reg <= product_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 6'd1;
                end
                FIX: begin
                    // Output registers load here so WB presents them with no input path.
                    result_reg <= fix_result;
                    wa_lo_reg  <= lo_addr_reg;
                    wa_hi_reg  <= hi_addr_reg;
                    flag_n_reg <= fix_result[2*N-1];
                    flag_z_reg <= (fix_result == '0);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == WB);
    assign we3    = done;
    assign w_64   = done;
    assign wa3_32 = wa_lo_reg;
    assign wa3_64 = wa_hi_reg;
    assign wd3_32 = result_reg[N-1:0];
    assign wd3_64 = result_reg[2*N-1:N];
    assign flag_n = flag_n_reg;
    assign flag_z = flag_z_reg;

endmodule

// File: tb/tb_long_mul_unit.sv
// Self-checking bench for long_mul_unit: directed cases from the multiply rules
// plus randomized operations compared against a plain-arithmetic reference.
module tb_long_mul_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic        accumulate;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] acc_lo;
    logic [31:0] acc_hi;
    logic [3:0]  rdlo_addr;
    logic [3:0]  rdhi_addr;
    logic        busy;
    logic        done;
    logic        we3;
    logic        w_64;
    logic [3:0]  wa3_32;
    logic [3:0]  wa3_64;
    logic [31:0] wd3_32;
    logic [31:0] wd3_64;
    logic        flag_n;
    logic        flag_z;

    int checks = 0;
    int errors = 0;

    long_mul_unit #(.N(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .accumulate(accumulate), .a(a), .b(b), .acc_lo(acc_lo), .acc_hi(acc_hi),
        .rdlo_addr(rdlo_addr), .rdhi_addr(rdhi_addr), .busy(busy), .done(done),
        .we3(we3), .w_64(w_64), .wa3_32(wa3_32), .wa3_64(wa3_64),
        .wd3_32(wd3_32), .wd3_64(wd3_64), .flag_n(flag_n), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(input logic sgn, input logic acc_en,
                                               input logic [31:0] x, input logic [31:0] y,
                                               input logic [63:0] acc);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic [63:0]        p;
        if (sgn) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            p  = sx * sy;
        end else begin
            p = {32'd0, x} * {32'd0, y};
        end
        if (acc_en) p = p + acc;
        return p;
    endfunction

    task automatic scramble_inputs();
        is_signed  = 1'($urandom_range(0, 1));
        accumulate = 1'($urandom_range(0, 1));
        a          = $urandom;
        b          = $urandom;
        acc_lo     = $urandom;
        acc_hi     = $urandom;
        rdlo_addr  = 4'($urandom_range(0, 15));
        rdhi_addr  = 4'($urandom_range(0, 15));
    endtask

    // Called at 1ns after a rising edge with the unit idle; returns at the same phase.
    task automatic run_op(input string name, input logic sgn, input logic acc_en,
                          input logic [31:0] x, input logic [31:0] y, input logic [63:0] acc,
                          input logic [3:0] lo, input logic [3:0] hi);
        logic [63:0] exp;
        int          lat;
        exp        = ref_result(sgn, acc_en, x, y, acc);
        start      = 1'b1;
        is_signed  = sgn;
        accumulate = acc_en;
        a          = x;
        b          = y;
        acc_lo     = acc[31:0];
        acc_hi     = acc[63:32];
        rdlo_addr  = lo;
        rdhi_addr  = hi;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_inputs();
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (lat != 34) begin
            errors++;
            $display("FAIL %s latency got %0d want 34", name, lat);
        end
        if (lat != 0) begin
            checks++;
            if ({wd3_64, wd3_32} !== exp) begin
                errors++;
                $display("FAIL %s result got %h_%h want %h_%h", name, wd3_64, wd3_32,
                         exp[63:32], exp[31:0]);
            end
            checks++;
            if (wa3_32 !== lo || wa3_64 !== hi) begin
                errors++;
                $display("FAIL %s addr got %0d/%0d want %0d/%0d", name, wa3_32, wa3_64, lo, hi);
            end
            checks++;
            if (we3 !== 1'b1 || w_64 !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s enables got we3=%b w_64=%b busy=%b want 1/1/1", name, we3, w_64, busy);
            end
            checks++;
            if (flag_n !== exp[63] || flag_z !== (exp == 64'd0)) begin
                errors++;
                $display("FAIL %s flags got N=%b Z=%b want N=%b Z=%b", name, flag_n, flag_z,
                         exp[63], (exp == 64'd0));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || we3 !== 1'b0 || w_64 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_wb got done=%b we3=%b w_64=%b busy=%b want 0", name, done, we3, w_64, busy);
        end
        checks++;
        if ({wd3_64, wd3_32} !== exp) begin
            errors++;
            $display("FAIL %s hold got %h_%h want %h_%h", name, wd3_64, wd3_32, exp[63:32], exp[31:0]);
        end
        $display("op %s sgn=%b acc=%b a=%h b=%h exp=%h latency=%0d", name, sgn, acc_en, x, y, exp, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        scramble_inputs();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, we3, w_64, flag_n, flag_z} !== 6'b0 ||
            {wd3_64, wd3_32} !== 64'd0 || wa3_32 !== 4'd0 || wa3_64 !== 4'd0) begin
            errors++;
            $display("FAIL reset_values got busy=%b done=%b data=%h_%h wa=%0d/%0d want all 0",
                     busy, done, wd3_64, wd3_32, wa3_32, wa3_64);
        end
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got busy=%b done=%b want 0/0", busy, done);
        end
        $display("reset test done");
    endtask

    task automatic test_directed();
        run_op("umull_max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 4'd2, 4'd3);
        run_op("smull_neg", 1'b1, 1'b0, 32'hFFFFFFFE, 32'd3, 64'd0, 4'd4, 4'd5);
        run_op("smull_min", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 64'd0, 4'd6, 4'd7);
        run_op("umlal_wrap", 1'b0, 1'b1, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFF, 4'd8, 4'd9);
        run_op("zero", 1'b0, 1'b0, 32'd0, 32'h12345678, 64'd0, 4'd1, 4'd10);
        run_op("smlal_mix", 1'b1, 1'b1, 32'h7FFFFFFF, 32'h80000001, 64'h00000001_00000000, 4'd11, 4'd12);
        run_op("same_addr", 1'b0, 1'b0, 32'h00010001, 32'h00010001, 64'd0, 4'd5, 4'd5);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = $urandom;
            y = $urandom;
            if (i % 6 == 0) x = 32'h80000000;
            if (i % 8 == 1) y = 32'hFFFFFFFF;
            run_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   x, y, {$urandom, $urandom}, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_busy_protection();
        logic [63:0] exp;
        int          n_done;
        exp        = ref_result(1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 64'd0);
        start      = 1'b1;
        is_signed  = 1'b0;
        accumulate = 1'b0;
        a          = 32'h12345678;
        b          = 32'h9ABCDEF0;
        rdlo_addr  = 4'd13;
        rdhi_addr  = 4'd14;
        @(posedge clk); #1;
        start  = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 80; c++) begin
            if (done) n_done++;
            if (c == 34) begin
                checks++;
                if (done !== 1'b1 || {wd3_64, wd3_32} !== exp) begin
                    errors++;
                    $display("FAIL busy_result got done=%b %h_%h want 1 %h_%h", done, wd3_64, wd3_32,
                             exp[63:32], exp[31:0]);
                end
            end
            if (c == 35) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_low got %b want 0", busy);
                end
            end
            if (c == 4 || c == 33) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL busy_single_done got %0d want 1", n_done);
        end
        $display("busy protection: done pulses=%0d result=%h_%h", n_done, wd3_64, wd3_32);
    endtask

    task automatic test_reset_midop();
        int n_we;
        start      = 1'b1;
        is_signed  = 1'b0;
        accumulate = 1'b0;
        a          = 32'hDEADBEEF;
        b          = 32'h0000FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        n_we  = 0;
        for (int c = 1; c <= 60; c++) begin
            if (we3 || w_64) n_we++;
            if (c == 10) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || {wd3_64, wd3_32} !== 64'd0) begin
                    errors++;
                    $display("FAIL midop_reset got busy=%b done=%b data=%h_%h want 0", busy, done,
                             wd3_64, wd3_32);
                end
            end
            reset = (c == 9);
            start = (c == 9);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if (n_we != 0) begin
            errors++;
            $display("FAIL midop_no_write got %0d pulses want 0", n_we);
        end
        $display("reset mid-op: write pulses=%0d", n_we);
        run_op("after_reset", 1'b0, 1'b0, 32'd7, 32'd6, 64'd0, 4'd2, 4'd3);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        scramble_inputs();
        #1;
        test_reset();
        test_directed();
        test_busy_protection();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/long_mul_unit.md
# long_mul_unit

Multicycle 32x32->64 long-multiply engine for the multicycle ARM core. It executes UMULL, SMULL, UMLAL and SMLAL, and acts as the writer for the register file's dual write port. On completion it drives the 32-bit (RdLo) and 64-bit-path (RdHi) write channels in a single cycle. The controller launches it with a one-cycle `start` and stalls on `busy` until `done`.

## Interface
- `N`, default 32: operand width. Only 32 is supported; result width is 2N.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch request; sampled only in IDLE.
- `is_signed`  in  1  1 selects SMULL/SMLAL, 0 selects UMULL/UMLAL.
- `accumulate`  in  1  1 adds {acc_hi,acc_lo} to the product.
- `a`  in  32  Rm operand.
- `b`  in  32  Rs operand.
- `acc_lo`  in  32  current RdLo value.
- `acc_hi`  in  32  current RdHi value.
- `rdlo_addr`  in  4  RdLo register index.
- `rdhi_addr`  in  4  RdHi register index.
- `busy`  out  1  high in MUL, FIX and WB states.
- `done`  out  1  one-cycle pulse in WB.
- `we3`  out  1  regfile 32-bit write enable; equals `done`.
- `w_64`  out  1  regfile high-word write enable; equals `done`.
- `wa3_32`  out  4  RdLo address.
- `wa3_64`  out  4  RdHi address.
- `wd3_32`  out  32  result[31:0].
- `wd3_64`  out  32  result[63:32].
- `flag_n`  out  1  result[63]; valid when `done`=1.
- `flag_z`  out  1  (result == 0); valid when `done`=1.

## Operation
- **States:** IDLE -> MUL -> FIX -> WB -> IDLE.
- **IDLE:**
  - On `start`=1, capture `a`, `b`, `acc_lo`, `acc_hi`, both addresses, `is_signed` and `accumulate`, then go to MUL.
  - Input changes after capture are ignored.
- **Capture (signed mode):** store |a| and |b| in 32-bit unsigned registers, plus neg = a[31]^b[31]. |0x80000000| = 0x80000000, treated as unsigned.
- **MUL:** radix-2 shift-add, 32 iterations, with a 6-bit counter running 0..31.
  - Each cycle, if multiplier LSB is 1, add the multiplicand into the 64-bit product.
  - Shift the multiplier right and the multiplicand left.
  - After iteration 31, go to FIX.
- **FIX:** single cycle, sequential within the cycle.
  1. If is_signed and neg, set product = ~product + 1 (mod 2^64).
  2. If accumulate, add {acc_hi,acc_lo} (mod 2^64); carry out is discarded.
  3. Go to WB.
- **WB:**
  - `done`=`we3`=`w_64`=1 for exactly one cycle.
  - `wd3_32`/`wd3_64`/`wa3_32`/`wa3_64` present the result and addresses.
  - Go to IDLE.
- **Ignored starts:** `start` in MUL, FIX or WB is ignored and not queued.
- **rdlo_addr == rdhi_addr:** both enables are still asserted. The regfile gives the high-word write priority, so the register ends up holding result[63:32].
- **Data outputs when idle:** data and address outputs hold the last result (Moore, registered). Enables are low outside WB.

## Timing
- With `start` sampled at edge k:
  - MUL occupies cycles k+1..k+32.
  - FIX occupies cycle k+33.
  - WB occupies cycle k+34.
  - The unit is back in IDLE after edge k+35.
- Latency from `start` edge to `done` is 34 cycles. The earliest next accepted `start` is at edge k+35.
- `busy` rises in the cycle after edge k and falls after the WB cycle.
- **Reset values:**
  - State = IDLE.
  - `busy`, `done`, `we3`, `w_64`, `flag_n` = 0.
  - `flag_z` = 0.
  - `wd3_32`, `wd3_64`, `wa3_32`, `wa3_64` = 0.
- **Reset mid-operation** (any state, including WB): the unit enters IDLE on that edge, outputs take reset values next cycle, and no register write occurs. A `start` coincident with `reset` is ignored.
- All outputs are registered or pure state decodes; there is no combinational path from inputs to outputs.

## Test plan
- **UMULL:** a=0xFFFFFFFF, b=0xFFFFFFFF, rdlo=2, rdhi=3.
  - `done` exactly 34 cycles after `start`.
  - wd3_64=0xFFFFFFFE, wd3_32=0x00000001, wa3_32=2, wa3_64=3.
  - we3=w_64=1 for one cycle; N=1, Z=0.
- **SMULL sign handling:**
  - a=-2, b=3 -> 0xFFFFFFFF_FFFFFFFA, N=1.
  - a=0x80000000, b=0x80000000 -> 0x40000000_00000000, N=0.
- **UMLAL wrap:** a=0xFFFFFFFF, b=2, acc=0xFFFFFFFF_FFFFFFFF -> hi=0x00000001, lo=0xFFFFFFFD. Carry is dropped.
- **Zero result:** a=0, b=0x12345678, accumulate=0 -> result 0, Z=1, N=0, enables still pulse.
- **Busy protection:**
  - Pulse `start` again at cycles k+5 and k+34, with `a`/`b` changed after capture.
  - Expect a single `done` at k+34 with the originally captured result.
  - No second launch occurs; `busy` is low at k+35.
- **Reset mid-op:** assert `reset` at cycle k+10.
  - `busy`=0 the next cycle and no we3/w_64 pulse ever.
  - A subsequent normal UMULL of 7x6 returns 0x00000000_0000002A.
